vram_write_scheduler: RTL and testbench

- Owns the single VRAM write port of the etch-a-sketch framebuffer.
- Schedules writes between two sources: touch-driven paint requests (valid/ready), and an internal clear sequencer that floods all VRAM_L locations with a colour.
- Sits between the touch/paint logic and the VRAM; the display controller keeps the read port.

---
 rtl/vram_write_scheduler_pkg.sv | 29 ++
 rtl/vram_write_scheduler_addr_gen.sv | 39 +++
 rtl/vram_write_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_vram_write_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler_pkg
// Shared definitions for the etch-a-sketch framebuffer path: ILI9341 panel
// geometry, RGB565 colour type and constants, VRAM address width and the
// write-scheduler state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package vram_write_scheduler_pkg;

  localparam int ILI9341_TFTWIDTH  = 240;
  localparam int ILI9341_TFTHEIGHT = 320;

  localparam int VRAM_DEPTH = ILI9341_TFTWIDTH * ILI9341_TFTHEIGHT;
  localparam int VRAM_AW    = $clog2(VRAM_DEPTH);

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RGB565_WHITE = 16'hFFFF;
  localparam rgb565_t RGB565_BLACK = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PAINT      = 3'd1,
    S_CLEAR_SYNC = 3'd2,
    S_CLEAR      = 3'd3,
    S_CLEAR_DONE = 3'd4
  } vram_sched_state_t;

endpackage

// File: rtl/vram_write_scheduler_addr_gen.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler_addr_gen (the vram_addr_gen mapper)
// Combinational pixel (x, y) -> linear VRAM address, row-major:
// addr = y*DISPLAY_WIDTH + x. Also usable by the display read path.
// Ports:
//   x_i        in   9   pixel column
//   y_i        in   9   pixel row
//   addr_o     out  AW  linear address (only meaningful when in_range_o)
//   in_range_o out  1   x < DISPLAY_WIDTH and y < DISPLAY_HEIGHT
// ---------------------------------------------------------------------------
module vram_write_scheduler_addr_gen
  import vram_write_scheduler_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = ILI9341_TFTWIDTH,
  parameter int DISPLAY_HEIGHT = ILI9341_TFTHEIGHT,
  parameter int AW             = VRAM_AW
) (
  input  logic [8:0]    x_i,
  input  logic [8:0]    y_i,
  output logic [AW-1:0] addr_o,
  output logic          in_range_o
);

  logic [AW-1:0] x_ext;
  logic [AW-1:0] y_ext;
  logic [AW-1:0] w_ext;

  always_comb begin
    // Widen before multiplying so the largest address (76799) fits.
    x_ext  = AW'(x_i);
    y_ext  = AW'(y_i);
    w_ext  = AW'(DISPLAY_WIDTH);
    addr_o = y_ext * w_ext + x_ext;
    // Range check on the raw 9-bit coordinates, independent of the product.
    in_range_o = (32'(x_i) < 32'(DISPLAY_WIDTH)) &&
                 (32'(y_i) < 32'(DISPLAY_HEIGHT));
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
// Owns the single VRAM write port. Arbitrates touch paint requests
// (valid/ready) against a full-screen clear sequencer; clear has priority.
//
// Optional build macro: VRAM_CLEAR_ON_VSYNC_EN
//   defined   : the clear waits for vsync before its first write
//   undefined : the clear starts one cycle after it is taken; vsync unused
//
// state        | meaning
// S_IDLE       | waiting; accepts paint, or takes a requested clear
// S_PAINT      | one-cycle write (or drop) of the latched paint request
// S_CLEAR_SYNC | clear taken, waiting for start condition
// S_CLEAR      | writing CLEAR_COLOR to every address, one per cycle
// S_CLEAR_DONE | one-cycle clear_done pulse
//
// Ports:
//   clk, rst (async active-low), ena (global enable)
//   clear_req in, clear_busy/clear_done out
//   paint_valid/paint_x/paint_y/paint_color in, paint_ready out
//   vsync in (frame-end strobe)
//   vram_wr_ena/vram_wr_addr/vram_wr_data out (VRAM write port)
//   drop_count out, saturating count of out-of-range paints
// ---------------------------------------------------------------------------
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int      DISPLAY_WIDTH  = ILI9341_TFTWIDTH,
  parameter int      DISPLAY_HEIGHT = ILI9341_TFTHEIGHT,
  parameter int      VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter rgb565_t CLEAR_COLOR    = RGB565_WHITE,
  localparam int     AW             = $clog2(VRAM_L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done,
  input  logic          paint_valid,
  output logic          paint_ready,
  input  logic [8:0]    paint_x,
  input  logic [8:0]    paint_y,
  input  logic [15:0]   paint_color,
  input  logic          vsync,
  output logic          vram_wr_ena,
  output logic [AW-1:0] vram_wr_addr,
  output logic [15:0]   vram_wr_data,
  output logic [7:0]    drop_count
);

  vram_sched_state_t state_q, state_d;
  logic              clear_pending_q, clear_pending_d;
  logic [AW-1:0]     clear_addr_q, clear_addr_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic [8:0]        paint_x_q, paint_x_d;
  logic [8:0]        paint_y_q, paint_y_d;
  rgb565_t           paint_color_q, paint_color_d;

  logic [AW-1:0]     paint_addr;
  logic              paint_in_range;

`ifndef VRAM_CLEAR_ON_VSYNC_EN
  logic unused_vsync;
  assign unused_vsync = vsync;
`endif

  vram_write_scheduler_addr_gen #(
    .DISPLAY_WIDTH  (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT (DISPLAY_HEIGHT),
    .AW             (AW)
  ) u_addr_gen (
    .x_i        (paint_x_q),
    .y_i        (paint_y_q),
    .addr_o     (paint_addr),
    .in_range_o (paint_in_range)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      clear_pending_q <= 1'b0;
      clear_addr_q    <= '0;
      drop_count_q    <= 8'd0;
      paint_x_q       <= 9'd0;
      paint_y_q       <= 9'd0;
      paint_color_q   <= RGB565_BLACK;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clear_addr_q    <= clear_addr_d;
      drop_count_q    <= drop_count_d;
      paint_x_q       <= paint_x_d;
      paint_y_q       <= paint_y_d;
      paint_color_q   <= paint_color_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clear_addr_d    = clear_addr_q;
    drop_count_d    = drop_count_q;
    paint_x_d       = paint_x_q;
    paint_y_d       = paint_y_q;
    paint_color_d   = paint_color_q;
    vram_wr_ena     = 1'b0;
    vram_wr_addr    = '0;
    vram_wr_data    = 16'h0000;
    clear_done      = 1'b0;

    paint_ready = ena && (state_q == S_IDLE) && !clear_req && !clear_pending_q;

    // With ena low nothing advances and no write strobe is issued.
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (clear_req || clear_pending_q) begin
            state_d         = S_CLEAR_SYNC;
            clear_pending_d = 1'b0;
          end else if (paint_valid && paint_ready) begin
            paint_x_d     = paint_x;
            paint_y_d     = paint_y;
            paint_color_d = paint_color;
            state_d       = S_PAINT;
          end
        end

        S_PAINT: begin
          if (paint_in_range) begin
            vram_wr_ena  = 1'b1;
            vram_wr_addr = paint_addr;
            vram_wr_data = paint_color_q;
          end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
          end
          // A clear requested mid-paint is remembered for the next idle cycle.
          if (clear_req) begin
            clear_pending_d = 1'b1;
          end
          state_d = S_IDLE;
        end

        S_CLEAR_SYNC: begin
`ifdef VRAM_CLEAR_ON_VSYNC_EN
          if (vsync) begin
            state_d = S_CLEAR;
          end
`else
          state_d = S_CLEAR;
`endif
        end

        S_CLEAR: begin
          vram_wr_ena  = 1'b1;
          vram_wr_addr = clear_addr_q;
          vram_wr_data = CLEAR_COLOR;
          if (clear_addr_q == AW'(VRAM_L - 1)) begin
            clear_addr_d = '0;
            state_d      = S_CLEAR_DONE;
          end else begin
            clear_addr_d = clear_addr_q + 1'b1;
          end
        end

        S_CLEAR_DONE: begin
          clear_done = 1'b1;
          state_d    = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign clear_busy = clear_pending_q ||
                      (state_q == S_CLEAR_SYNC) || (state_q == S_CLEAR);
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
module tb_vram_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        clear_req;
  logic        paint_valid;
  logic [8:0]  p_x;
  logic [8:0]  p_y;
  logic [15:0] p_c;
  logic        vsync;

  logic        clear_busy;
  logic        clear_done;
  logic        paint_ready;
  logic        vram_wr_ena;
  logic [16:0] vram_wr_addr;
  logic [15:0] vram_wr_data;
  logic [7:0]  drop_count;

`ifdef VRAM_CLEAR_ON_VSYNC_EN
  localparam int EXP_FIRST = 0;
`else
  localparam int EXP_FIRST = 1;
`endif

  vram_write_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .paint_valid  (paint_valid),
    .paint_ready  (paint_ready),
    .paint_x      (p_x),
    .paint_y      (p_y),
    .paint_color  (p_c),
    .vsync        (vsync),
    .vram_wr_ena  (vram_wr_ena),
    .vram_wr_addr (vram_wr_addr),
    .vram_wr_data (vram_wr_data),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
    bit          wr;
    int          addr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_paint(input int idx, input vec_t v);
    @(negedge clk);
    paint_valid = 1'b1;
    p_x = v.x;
    p_y = v.y;
    p_c = v.c;
    #1 check($sformatf("ready_at_accept[%0d]", idx), 32'(paint_ready), 1);
    @(negedge clk);
    paint_valid = 1'b0;
    #1;
    check($sformatf("wr_ena[%0d]", idx), 32'(vram_wr_ena), 32'(v.wr));
    if (v.wr) begin
      check($sformatf("wr_addr[%0d]", idx), 32'(vram_wr_addr), v.addr);
      check($sformatf("wr_data[%0d]", idx), 32'(vram_wr_data), 32'(v.c));
    end
    check($sformatf("ready_in_paint[%0d]", idx), 32'(paint_ready), 0);
    if (!v.wr) exp_drop++;
    @(negedge clk);
    #1 check($sformatf("drop_count[%0d]", idx), 32'(drop_count), exp_drop);
  endtask

  task automatic quick_drop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      paint_valid = 1'b1;
      p_x = 9'd240;
      p_y = 9'd0;
      @(negedge clk);
      paint_valid = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic start_clear(input bit with_paint);
    @(negedge clk);
    clear_req = 1'b1;
    if (with_paint) begin
      paint_valid = 1'b1;
      p_x = 9'd5;
      p_y = 9'd1;
      p_c = 16'hF800;
    end
    #1 check("ready_low_on_clear_req", 32'(paint_ready), 0);
    @(negedge clk);
    clear_req = 1'b0;
    #1 check("busy_in_sync", 32'(clear_busy), 1);
`ifdef VRAM_CLEAR_ON_VSYNC_EN
    for (int i = 0; i < 3; i++) begin
      check("no_write_before_vsync", 32'(vram_wr_ena), 0);
      @(negedge clk);
      #1;
    end
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    #1;
`endif
  endtask

  // Follows a clear from the current sample point. Counts writes, flags any
  // gap, wrong address/data, busy low or ready high while writing.
  task automatic run_clear(input int pause_at, input int stop_at,
                           output int writes, output int errs,
                           output int first_iter, output bit done_ok);
    bit last_final = 1'b0;
    bit paused     = 1'b0;
    bit done       = 1'b0;
    writes = 0; errs = 0; first_iter = -1; done_ok = 1'b0;
    for (int it = 0; it < 80000 && !done; it++) begin
      if (pause_at >= 0 && writes == pause_at && !paused) begin
        paused = 1'b1;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          if (vram_wr_ena || clear_done || paint_ready) errs++;
          @(negedge clk);
        end
        ena = 1'b1;
        #1;
      end
      if (vram_wr_ena) begin
        if (first_iter < 0) first_iter = it;
        if (32'(vram_wr_addr) != writes || vram_wr_data != 16'hFFFF ||
            !clear_busy || paint_ready) errs++;
        last_final = (32'(vram_wr_addr) == 76799);
        writes++;
        if (stop_at >= 0 && 32'(vram_wr_addr) == stop_at) done = 1'b1;
      end else begin
        if (clear_done) begin
          done    = 1'b1;
          done_ok = last_final;
        end else if (writes > 0) begin
          errs++;
        end
        last_final = 1'b0;
      end
      if (!done) begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) errs++;
  endtask

  int writes, errs, first_iter, stray;
  bit done_ok;

  initial begin
    rst = 1'b0; ena = 1'b1; clear_req = 1'b0; paint_valid = 1'b0;
    p_x = '0; p_y = '0; p_c = '0; vsync = 1'b0;

    vecs[0] = '{x: 9'd10,  y: 9'd2,   c: 16'h001F, wr: 1'b1, addr: 490};
    vecs[1] = '{x: 9'd0,   y: 9'd0,   c: 16'h07E0, wr: 1'b1, addr: 0};
    vecs[2] = '{x: 9'd239, y: 9'd319, c: 16'h1234, wr: 1'b1, addr: 76799};
    vecs[3] = '{x: 9'd240, y: 9'd0,   c: 16'hAAAA, wr: 1'b0, addr: 0};
    vecs[4] = '{x: 9'd0,   y: 9'd320, c: 16'h5555, wr: 1'b0, addr: 0};
    vecs[5] = '{x: 9'd239, y: 9'd0,   c: 16'hF800, wr: 1'b1, addr: 239};
    vecs[6] = '{x: 9'd0,   y: 9'd1,   c: 16'h0001, wr: 1'b1, addr: 240};
    vecs[7] = '{x: 9'd511, y: 9'd511, c: 16'hBEEF, wr: 1'b0, addr: 0};
    vecs[8] = '{x: 9'd100, y: 9'd100, c: 16'hC0DE, wr: 1'b1, addr: 24100};
    vecs[9] = '{x: 9'd0,   y: 9'd319, c: 16'h8001, wr: 1'b1, addr: 76560};

    #2;
    check("rst_wr_ena", 32'(vram_wr_ena), 0);
    check("rst_wr_addr", 32'(vram_wr_addr), 0);
    check("rst_wr_data", 32'(vram_wr_data), 0);
    check("rst_busy", 32'(clear_busy), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_ready", 32'(paint_ready), 1);
    #10 rst = 1'b1;

    for (int i = 0; i < 10; i++) do_paint(i, vecs[i]);

    quick_drop(251);
    check("drop_254", 32'(drop_count), 254);
    quick_drop(49);
    check("drop_saturated", 32'(drop_count), 255);

    // Clear with a simultaneous paint held at its source, ena paused at 1000.
    start_clear(1'b1);
    run_clear(1000, -1, writes, errs, first_iter, done_ok);
    check("clear_writes", 32'(writes), 76800);
    check("clear_seq_errors", 32'(errs), 0);
    check("clear_done_after_last", 32'(done_ok), 1);
    check("clear_first_write_cycle", 32'(first_iter), EXP_FIRST);
    check("clear_done_busy_low", 32'(clear_busy), 0);
    check("drop_kept_through_clear", 32'(drop_count), 255);
    @(negedge clk);
    #1 check("held_paint_ready", 32'(paint_ready), 1);
    @(negedge clk);
    paint_valid = 1'b0;
    #1;
    check("held_paint_wr_ena", 32'(vram_wr_ena), 1);
    check("held_paint_addr", 32'(vram_wr_addr), 245);
    check("held_paint_data", 32'(vram_wr_data), 32'h0000F800);

    // Asynchronous reset in the middle of a clear.
    start_clear(1'b0);
    run_clear(-1, 5000, writes, errs, first_iter, done_ok);
    check("pre_reset_writes", 32'(writes), 5001);
    check("pre_reset_errors", 32'(errs), 0);
    #1 rst = 1'b0;
    #1;
    check("async_rst_wr_ena", 32'(vram_wr_ena), 0);
    check("async_rst_addr", 32'(vram_wr_addr), 0);
    check("async_rst_data", 32'(vram_wr_data), 0);
    check("async_rst_busy", 32'(clear_busy), 0);
    check("async_rst_done", 32'(clear_done), 0);
    check("async_rst_drop", 32'(drop_count), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (vram_wr_ena || clear_done || clear_busy) stray++;
    end
    check("no_activity_after_reset", 32'(stray), 0);
    check("ready_after_reset", 32'(paint_ready), 1);

    // The abandoned clear must restart from address 0.
    start_clear(1'b0);
    run_clear(-1, 3, writes, errs, first_iter, done_ok);
    check("restart_from_zero_errors", 32'(errs), 0);
    check("restart_writes", 32'(writes), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
